// File: rtl/sub_word_arbiter.sv
// rtl/sub_word_arbiter.sv - two-requester arbiter in front of one shared Sub_Word unit
//
// Purpose:
//   Grants one 32-bit word per cycle from either the key-expansion requester (0)
//   or the round datapath requester (1), drives the shared Sub_Word input
//   register, and follows each accepted word through the ROM latency with a
//   {valid, id} tag pipeline so the substituted word returns to its issuer,
//   in acceptance order, at one word per cycle.
//
// Configuration:
//   SUB_WORD_ARB_RR_EN  defined   -> round-robin on conflict (1-bit pointer)
//                       undefined -> requester 0 always wins on conflict
//
// Parameters:
//   ROM_LAT     read latency of the shared Sub_Word in clock edges (1..4)
//
// Ports:
//   CLK, RST               clock; synchronous active-high reset
//   REQx_VALID/DATA/READY  request handshake for requester x (0 or 1)
//   RSPx_VALID/DATA        returned substituted word for requester x
//   SW_IN                  registered word to the shared Sub_Word input
//   SW_OUT                 shared Sub_Word output
//   BUSY                   at least one accepted word is still in flight

module sub_word_arbiter #(
  parameter int ROM_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0_VALID,
  input  logic [0:31] REQ0_DATA,
  output logic        REQ0_READY,
  output logic        RSP0_VALID,
  output logic [0:31] RSP0_DATA,
  input  logic        REQ1_VALID,
  input  logic [0:31] REQ1_DATA,
  output logic        REQ1_READY,
  output logic        RSP1_VALID,
  output logic [0:31] RSP1_DATA,
  output logic [0:31] SW_IN,
  input  logic [0:31] SW_OUT,
  output logic        BUSY
);

  // Stage k of the tag pipeline lines up with the word that entered SW_IN
  // k+1 edges ago; the last stage lines up with SW_OUT.
  localparam int DEPTH = ROM_LAT + 1;

  logic [DEPTH-1:0] tag_valid;
  logic [DEPTH-1:0] tag_id;
  logic             grant1;   // 1: requester 1 wins this cycle
  logic             accept;

`ifdef SUB_WORD_ARB_RR_EN
  logic rr_ptr;               // favoured requester on conflict

  always_comb begin
    grant1 = 1'b0;
    if (REQ0_VALID && REQ1_VALID) begin
      grant1 = rr_ptr;
    end else begin
      grant1 = REQ1_VALID;
    end
  end

  // Pointer hands priority to the other requester after every accept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~grant1;
    end
  end
`else
  always_comb begin
    grant1 = 1'b0;
    grant1 = REQ1_VALID && !REQ0_VALID;
  end
`endif

  assign REQ0_READY = !RST && REQ0_VALID && !grant1;
  assign REQ1_READY = !RST && REQ1_VALID && grant1;
  assign accept     = REQ0_READY || REQ1_READY;

  // SW_IN holds its value when idle so the always-enabled ROMs do not toggle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      SW_IN     <= 32'h0;
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      if (accept) begin
        SW_IN <= grant1 ? REQ1_DATA : REQ0_DATA;
      end
      tag_valid <= {tag_valid[DEPTH-2:0], accept};
      tag_id    <= {tag_id[DEPTH-2:0], grant1};
    end
  end

  // Responses and BUSY are masked during reset so in-flight tags never leak.
  assign RSP0_VALID = !RST && tag_valid[DEPTH-1] && !tag_id[DEPTH-1];
  assign RSP1_VALID = !RST && tag_valid[DEPTH-1] &&  tag_id[DEPTH-1];
  assign RSP0_DATA  = SW_OUT;
  assign RSP1_DATA  = SW_OUT;
  assign BUSY       = !RST && (|tag_valid);

endmodule

// File: tb/tb_sub_word_arbiter.sv
// tb/tb_sub_word_arbiter.sv - self-checking bench for sub_word_arbiter (ROM_LAT 1 and 2)

module tb_sub_word_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v0, v1;
  logic [31:0] d0, d1;

  logic        rdy0_a, rdy1_a, rv0_a, rv1_a, busy_a;
  logic [31:0] rd0_a, rd1_a, swi_a, swo_a;
  logic        rdy0_b, rdy1_b, rv0_b, rv1_b, busy_b;
  logic [31:0] rd0_b, rd1_b, swi_b, swo_b;

  sub_word_arbiter #(.ROM_LAT(1)) dut_a (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(v0), .REQ0_DATA(d0), .REQ0_READY(rdy0_a),
    .RSP0_VALID(rv0_a), .RSP0_DATA(rd0_a),
    .REQ1_VALID(v1), .REQ1_DATA(d1), .REQ1_READY(rdy1_a),
    .RSP1_VALID(rv1_a), .RSP1_DATA(rd1_a),
    .SW_IN(swi_a), .SW_OUT(swo_a), .BUSY(busy_a)
  );

  sub_word_arbiter #(.ROM_LAT(2)) dut_b (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(v0), .REQ0_DATA(d0), .REQ0_READY(rdy0_b),
    .RSP0_VALID(rv0_b), .RSP0_DATA(rd0_b),
    .REQ1_VALID(v1), .REQ1_DATA(d1), .REQ1_READY(rdy1_b),
    .RSP1_VALID(rv1_b), .RSP1_DATA(rd1_b),
    .SW_IN(swi_b), .SW_OUT(swo_b), .BUSY(busy_b)
  );

  // AES S-box computed from GF(2^8) inverse plus affine transform.
  logic [7:0] sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Shared Sub_Word models: registered read with 1 and 2 edges of latency.
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [0:1];
  always @(posedge clk) begin
    pipe_a    <= sub_word(swi_a);
    pipe_b[0] <= sub_word(swi_b);
    pipe_b[1] <= pipe_b[0];
  end
  assign swo_a = pipe_a;
  assign swo_b = pipe_b[1];

  // Reference model: per-cycle history of accepts and resets.
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_rst = -1;
  bit          acc_v  [0:4095];
  bit          acc_id [0:4095];
  logic [31:0] acc_d  [0:4095];
  logic [31:0] sw_model = 32'h0;
  bit          ptr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_resp(input string nm, input int lat, input logic rv0, input logic rv1,
                            input logic [31:0] rd0, input logic [31:0] rd1, input logic busy);
    int          c;
    bit          ev, eid, eb;
    logic [31:0] ed;
    c = cyc - 1 - lat;
    ev = 0; eid = 0; ed = 32'h0; eb = 0;
    if (c >= 0 && acc_v[c] && last_rst < c + 1) begin
      ev = 1; eid = acc_id[c]; ed = sub_word(acc_d[c]);
    end
    chk({nm, "_rsp0_valid"}, {31'b0, rv0}, {31'b0, ev && !eid});
    chk({nm, "_rsp1_valid"}, {31'b0, rv1}, {31'b0, ev && eid});
    if (ev && !eid) chk({nm, "_rsp0_data"}, rd0, ed);
    if (ev && eid)  chk({nm, "_rsp1_data"}, rd1, ed);
    for (int k = cyc - 1 - lat; k <= cyc - 1; k++)
      if (k >= 0 && acc_v[k] && last_rst < k + 1) eb = 1;
    chk({nm, "_busy"}, {31'b0, busy}, {31'b0, eb});
  endtask

  // One clock cycle: drive after the edge, check at the falling edge, then
  // advance the model across the coming rising edge.
  task automatic run_cycle(input bit r, input bit iv0, input logic [31:0] id0,
                           input bit iv1, input logic [31:0] id1,
                           output bit a0, output bit a1);
    bit g0, g1;
    @(posedge clk); #1;
    rst = r; v0 = iv0; d0 = id0; v1 = iv1; d1 = id1;
    @(negedge clk);
    if (r) last_rst = cyc;
    g0 = 0; g1 = 0;
    if (!r) begin
      if (iv0 && iv1) begin
`ifdef SUB_WORD_ARB_RR_EN
        if (ptr) g1 = 1; else g0 = 1;
`else
        g0 = 1;
`endif
      end else begin
        g0 = iv0; g1 = iv1;
      end
    end
    chk("a_ready0", {31'b0, rdy0_a}, {31'b0, g0});
    chk("a_ready1", {31'b0, rdy1_a}, {31'b0, g1});
    chk("b_ready0", {31'b0, rdy0_b}, {31'b0, g0});
    chk("b_ready1", {31'b0, rdy1_b}, {31'b0, g1});
    check_resp("a", 1, rv0_a, rv1_a, rd0_a, rd1_a, busy_a);
    check_resp("b", 2, rv0_b, rv1_b, rd0_b, rd1_b, busy_b);
    chk("a_sw_in", swi_a, sw_model);
    chk("b_sw_in", swi_b, sw_model);
    acc_v[cyc]  = g0 | g1;
    acc_id[cyc] = g1;
    acc_d[cyc]  = g1 ? id1 : id0;
    if (r) begin
      sw_model = 32'h0; ptr = 1'b0;
    end else if (g0 | g1) begin
      sw_model = acc_d[cyc]; ptr = g0;
    end
    cyc++;
    a0 = g0; a1 = g1;
  endtask

  bit          a0, a1, pv0, pv1, rr;
  logic [31:0] pd0, pd1;
  bit          exp_r0 [4];
  bit          exp_r1 [4];
  int          nrsp;

  initial begin
    for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(i[7:0]);
    rst = 1'b1; v0 = 0; v1 = 0; d0 = 0; d1 = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    run_cycle(1, 0, 0, 0, 0, a0, a1);
    chk("reset_sw_in", swi_a, 32'h0);
    run_cycle(1, 1, 32'h01020304, 1, 32'h05060708, a0, a1);
    chk("reset_ready0", {31'b0, rdy0_a}, 32'h0);
    chk("reset_busy", {31'b0, busy_a}, 32'h0);

    // Single request.
    run_cycle(0, 1, 32'h000102FF, 0, 0, a0, a1);
    run_cycle(0, 0, 0, 0, 0, a0, a1);
    chk("single_busy_c1", {31'b0, busy_a}, 32'h1);
    chk("single_rsp0_c1", {31'b0, rv0_a}, 32'h0);
    run_cycle(0, 0, 0, 0, 0, a0, a1);
    chk("single_rsp0_c2", {31'b0, rv0_a}, 32'h1);
    chk("single_data_c2", rd0_a, 32'h637C7716);
    chk("single_rsp1_c2", {31'b0, rv1_a}, 32'h0);
    run_cycle(0, 0, 0, 0, 0, a0, a1);
    chk("single_rsp0_c3", {31'b0, rv0_a}, 32'h0);
    chk("single_busy_c3", {31'b0, busy_a}, 32'h0);

    // Interleaved streaming: 8 alternating words, 8 consecutive responses.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) run_cycle(0, 1, 32'h10203040 + i * 32'h01010101, 0, 0, a0, a1);
      else            run_cycle(0, 0, 0, 1, 32'h9A8B7C6D + i * 32'h03050709, a0, a1);
      if (i >= 2) chk("stream_rsp", {31'b0, (i % 2 == 0) ? rv0_a : rv1_a}, 32'h1);
    end
    nrsp = 0;
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 0, 0, 0, 0, a0, a1);
      if (rv0_a || rv1_a) nrsp++;
    end
    chk("stream_tail_count", nrsp, 2);

    // Conflict: both requesters held valid for 4 cycles after a fresh reset.
    run_cycle(1, 0, 0, 0, 0, a0, a1);
`ifdef SUB_WORD_ARB_RR_EN
    exp_r0 = '{1, 0, 1, 0}; exp_r1 = '{0, 1, 0, 1};
`else
    exp_r0 = '{1, 1, 1, 1}; exp_r1 = '{0, 0, 0, 0};
`endif
    pv0 = 1; pd0 = 32'hC0C1C2C3; pv1 = 1; pd1 = 32'hD0D1D2D3;
    for (int i = 0; i < 4; i++) begin
      run_cycle(0, pv0, pd0, pv1, pd1, a0, a1);
      chk("conflict_ready0", {31'b0, rdy0_a}, {31'b0, exp_r0[i]});
      chk("conflict_ready1", {31'b0, rdy1_a}, {31'b0, exp_r1[i]});
      if (a0) pd0 = pd0 + 32'h11111111;
      if (a1) pd1 = pd1 + 32'h01010101;
    end
    for (int i = 0; i < 4; i++) begin
      if (pv0 || pv1) begin
        run_cycle(0, pv0, pd0, pv1, pd1, a0, a1);
        if (a0) pv0 = 0;
        if (a1) pv1 = 0;
      end
    end
    repeat (3) run_cycle(0, 0, 0, 0, 0, a0, a1);

    // Reset mid-flight.
    run_cycle(0, 1, 32'h53535353, 0, 0, a0, a1);
    run_cycle(1, 0, 0, 0, 0, a0, a1);
    chk("midrst_rsp0_during", {31'b0, rv0_a}, 32'h0);
    run_cycle(0, 1, 32'h000102FF, 0, 0, a0, a1);
    chk("midrst_sw_in", swi_a, 32'h0);
    chk("midrst_busy", {31'b0, busy_a}, 32'h0);
    chk("midrst_rsp0", {31'b0, rv0_a}, 32'h0);
    chk("midrst_ready0", {31'b0, rdy0_a}, 32'h1);
    run_cycle(0, 0, 0, 0, 0, a0, a1);
    run_cycle(0, 0, 0, 0, 0, a0, a1);
    chk("midrst_new_rsp0", {31'b0, rv0_a}, 32'h1);
    chk("midrst_new_data", rd0_a, 32'h637C7716);
    repeat (2) run_cycle(0, 0, 0, 0, 0, a0, a1);

    // ROM latency 2 (instance b).
    run_cycle(0, 0, 0, 1, 32'h53000000, a0, a1);
    run_cycle(0, 0, 0, 0, 0, a0, a1);
    run_cycle(0, 0, 0, 0, 0, a0, a1);
    chk("lat2_rsp1_early", {31'b0, rv1_b}, 32'h0);
    run_cycle(0, 0, 0, 0, 0, a0, a1);
    chk("lat2_rsp1", {31'b0, rv1_b}, 32'h1);
    chk("lat2_data", rd1_b, 32'hED636363);
    run_cycle(0, 0, 0, 0, 0, a0, a1);

    // Idle hold.
    run_cycle(0, 1, 32'hDEADBEEF, 0, 0, a0, a1);
    for (int i = 0; i < 5; i++) begin
      run_cycle(0, 0, 0, 0, 0, a0, a1);
      chk("idle_sw_in", swi_a, 32'hDEADBEEF);
      chk("idle_ready", {30'b0, rdy0_a, rdy1_a}, 32'h0);
    end
    chk("idle_no_rsp", {30'b0, rv0_a, rv1_a}, 32'h0);

    // Randomized traffic with occasional resets; requesters hold until READY.
    pv0 = 0; pv1 = 0; pd0 = 0; pd1 = 0;
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 59) == 0);
      if (!pv0 && $urandom_range(0, 3) != 0) begin pv0 = 1; pd0 = $urandom; end
      if (!pv1 && $urandom_range(0, 3) != 0) begin pv1 = 1; pd1 = $urandom; end
      run_cycle(rr, pv0, pd0, pv1, pd1, a0, a1);
      if (a0) pv0 = 0;
      if (a1) pv1 = 0;
    end
    repeat (4) run_cycle(0, 0, 0, 0, 0, a0, a1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_word_arbiter.md
# sub_word_arbiter

Shares one `Sub_Word` unit (four 8-bit S-box ROMs, registered read) between two requesters: requester 0 is key expansion (RotWord/SubWord path) and requester 1 is the round datapath's column-wise SubBytes. The block does four things:
- arbitrates one 32-bit word per cycle;
- drives the shared unit's input;
- tracks each accepted word through the ROM latency with a tag pipeline;
- returns the substituted word to the requester that issued it, in order and at full throughput.

## Interface
- `ROM_LAT`, default 1: read latency of the shared `Sub_Word` in clock edges. Legal range is 1–4.
- `CLK` in 1: the single clock. All logic is on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `REQ0_VALID` in 1: requester 0 presents a word.
- `REQ0_DATA` in 32 `[0:31]`: word from requester 0. Bit 0 is the MSB; byte 0 is `[0:7]`.
- `REQ0_READY` out 1: the word from requester 0 is accepted this cycle.
- `RSP0_VALID` out 1: the substituted word for requester 0 is on `RSP0_DATA`.
- `RSP0_DATA` out 32 `[0:31]`: substituted word for requester 0.
- `REQ1_VALID`, `REQ1_DATA`, `REQ1_READY`, `RSP1_VALID`, `RSP1_DATA`: same as the requester 0 ports, for requester 1.
- `SW_IN` out 32 `[0:31]`: registered word driven to the shared `Sub_Word` INPUT.
- `SW_OUT` in 32 `[0:31]`: OUTPUT of the shared `Sub_Word`.
- `BUSY` out 1: at least one accepted word has not yet been returned.

## Operation
**Acceptance**
- A word is accepted from requester x in cycle c when `REQx_VALID` and `REQx_READY` are both high in cycle c.
- At most one word is accepted per cycle.
- `REQx_READY` is combinational from both VALIDs and the arbitration state. It is high only for the granted requester, and only when that requester's VALID is high and `RST` is low.
- Requesters must hold VALID and DATA stable until READY.

**Arbitration**
- Priority is set by the configuration macro (see Configuration).
- A lone valid requester is always granted.

**Issue**
- On the edge that ends cycle c, `SW_IN` loads `REQx_DATA`.
- When nothing is accepted, `SW_IN` holds its previous value. The ROMs are always enabled, so holding the value means no extra toggling.

**Tag pipeline**
- The pipeline is a `ROM_LAT+1`-deep shift register of {valid, id}.
- Stage 0 is loaded on acceptance with {1, x}, or with {0, –} if nothing is accepted.
- The pipeline shifts every cycle.

**Return**
- `RSPx_VALID` = last stage valid && last stage id == x.
- `RSP0_DATA` and `RSP1_DATA` are both wired to `SW_OUT`. Data is meaningful only while the corresponding VALID is high.
- There is no response backpressure: the requester must take the word in its VALID cycle.

**Ordering and bookkeeping**
- Responses are returned in acceptance order globally, and therefore also per requester.
- `BUSY` = OR of all tag valid bits.

## Timing
- Acceptance in cycle c produces the response in cycle c+1+`ROM_LAT`. With the default this is cycle c+2.
- Throughput is one word per cycle sustained, in any interleave of the two requesters.
- Back-to-back accepts in cycles c and c+1 give responses in consecutive cycles, one per cycle, in that order.

**Reset values** (while `RST` is high, and at the first edge after reset):
- `REQ0_READY` = `REQ1_READY` = 0.
- `RSP0_VALID` = `RSP1_VALID` = 0.
- `SW_IN` = 32'h0.
- `BUSY` = 0.
- All tag valid bits = 0.
- Round-robin pointer set to favour requester 0.

**Reset mid-operation**
- In-flight tags are discarded and no response is emitted for them.
- The first accept after `RST` falls can occur in the first cycle with `RST` low.

**Boundary conditions**
- Simultaneous valid requests: exactly one is granted. The loser's READY is 0 and it retries the next cycle.
- Accept in the same cycle as a response: legal. Stage 0 loads while the last stage presents.

## Configuration
`SUB_WORD_ARB_RR_EN`
- **Defined:** round-robin arbitration.
  - A 1-bit pointer names the favoured requester.
  - After each accept, the pointer moves to the other requester.
  - On simultaneous requests, the favoured requester is granted.
- **Undefined:** fixed priority. Requester 0 (key expansion) always wins on conflict, and no pointer register exists.

## Test plan
- **Single request.** Reset, then `REQ0` word 32'h000102FF accepted in cycle c.
  - `RSP0_VALID` is high only in cycle c+2, with `RSP0_DATA` = 32'h637C7716.
  - `RSP1_VALID` stays 0.
  - `BUSY` is high in cycles c+1..c+2.
- **Interleaved streaming.** `REQ0`/`REQ1` alternate every cycle for 8 cycles with distinct words.
  - 8 responses in 8 consecutive cycles, each on the correct port with the correct S-box result.
- **Conflict, round-robin.** Both VALIDs held high for 4 cycles with `SUB_WORD_ARB_RR_EN` defined.
  - Grants go 0,1,0,1.
  - With the macro undefined: grants go 0,0,0,0, and `REQ1_READY` stays 0.
- **Reset mid-flight.** Accept 32'h53535353, then assert `RST` in cycle c+1.
  - No `RSPx_VALID`; `BUSY` = 0 after the edge.
  - `SW_IN` = 0.
  - A new accept in the first cycle after reset returns normally 2 cycles later.
- **ROM latency 2.** `ROM_LAT`=2, `REQ1` 32'h53000000 accepted in cycle c.
  - `RSP1_VALID` is high in cycle c+3, with `RSP1_DATA` = 32'hED636363.
- **Idle hold.** No VALID for 5 cycles after an accept.
  - `SW_IN` is unchanged.
  - READYs stay 0.
  - No spurious responses.
